// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: converts signed (x,y) into gain-compensated
// magnitude and full-circle angle atan2(y,x) in Q3.13 radians, one stage per clock.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | ready=1, waiting for start; pre-rotates and loads on accept
//  S_ITER  | one micro-rotation per clock on stage cnt
//  S_SCALE | applies 1/K gain, clamps angle, pulses done, back to idle
module cordic_vectoring #(
    parameter int ITERATIONS = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    output logic        ready,
    output logic        done,
    output logic [15:0] mag_o,
    output logic [15:0] angle_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ITER  = 2'd1;
    localparam logic [1:0] S_SCALE = 2'd2;

    localparam logic signed [15:0] HALF_PI = 16'sh3244;
    localparam logic signed [15:0] PI_Q    = 16'sh6488;
    // K = 0.60725 in Q1.15, zero-extended so the product stays signed
    localparam logic signed [16:0] K_GAIN  = 17'sh04DBA;
    localparam logic [3:0]         LAST    = 4'(ITERATIONS - 1);

    logic [1:0]         state;
    logic [3:0]         cnt;
    logic signed [18:0] x_r;
    logic signed [18:0] y_r;
    logic signed [15:0] z_r;
    logic               zero_r;

    logic signed [18:0] x_ext;
    logic signed [18:0] y_ext;
    logic signed [18:0] x_pre;
    logic signed [18:0] y_pre;
    logic signed [15:0] z_pre;
    logic signed [18:0] x_sh;
    logic signed [18:0] y_sh;
    logic signed [15:0] atan_i;
    logic signed [35:0] prod;
    logic signed [35:0] scaled;
    logic [15:0]        mag_sat;
    logic signed [15:0] z_clamp;

    function automatic logic signed [15:0] atan_lut(input logic [3:0] i);
        logic signed [15:0] v;
        case (i)
            4'd0:    v = 16'sh1922;
            4'd1:    v = 16'sh0ED6;
            4'd2:    v = 16'sh07D7;
            4'd3:    v = 16'sh03FB;
            4'd4:    v = 16'sh01FF;
            4'd5:    v = 16'sh0100;
            4'd6:    v = 16'sh0080;
            4'd7:    v = 16'sh0040;
            4'd8:    v = 16'sh0020;
            4'd9:    v = 16'sh0010;
            4'd10:   v = 16'sh0008;
            4'd11:   v = 16'sh0004;
            4'd12:   v = 16'sh0002;
            4'd13:   v = 16'sh0001;
            default: v = 16'sh0000;
        endcase
        return v;
    endfunction

    assign x_ext = {{3{x_i[15]}}, x_i};
    assign y_ext = {{3{y_i[15]}}, y_i};

    // Fold the left half-plane onto x>=0 with a +/-pi/2 rotation
    always_comb begin
        x_pre = x_ext;
        y_pre = y_ext;
        z_pre = 16'sh0000;
        if (x_i[15]) begin
            if (!y_i[15]) begin
                x_pre = y_ext;
                y_pre = -x_ext;
                z_pre = HALF_PI;
            end else begin
                x_pre = -y_ext;
                y_pre = x_ext;
                z_pre = -HALF_PI;
            end
        end
    end

    assign x_sh   = x_r >>> cnt;
    assign y_sh   = y_r >>> cnt;
    assign atan_i = atan_lut(cnt);

    assign prod   = x_r * K_GAIN;
    assign scaled = prod >>> 15;

    always_comb begin
        if (scaled < 36'sd0)
            mag_sat = 16'h0000;
        else if (scaled > 36'sd65535)
            mag_sat = 16'hFFFF;
        else
            mag_sat = scaled[15:0];
    end

    always_comb begin
        if (z_r > PI_Q)
            z_clamp = PI_Q;
        else if (z_r < -PI_Q)
            z_clamp = -PI_Q;
        else
            z_clamp = z_r;
    end

    assign ready = (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            x_r     <= '0;
            y_r     <= '0;
            z_r     <= '0;
            zero_r  <= 1'b0;
            done    <= 1'b0;
            mag_o   <= 16'h0000;
            angle_o <= 16'h0000;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_r    <= x_pre;
                        y_r    <= y_pre;
                        z_r    <= z_pre;
                        zero_r <= (x_i == 16'h0000) && (y_i == 16'h0000);
                        cnt    <= 4'd0;
                        state  <= S_ITER;
                    end
                end
                S_ITER: begin
                    if (!y_r[18]) begin
                        x_r <= x_r + y_sh;
                        y_r <= y_r - x_sh;
                        z_r <= z_r + atan_i;
                    end else begin
                        x_r <= x_r - y_sh;
                        y_r <= y_r + x_sh;
                        z_r <= z_r - atan_i;
                    end
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST)
                        state <= S_SCALE;
                end
                S_SCALE: begin
                    // A zero vector has no defined angle; report all zeros
                    mag_o   <= zero_r ? 16'h0000 : mag_sat;
                    angle_o <= zero_r ? 16'h0000 : z_clamp;
                    done    <= 1'b1;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed bench for cordic_vectoring: hand-traced vectors, handshake corner
// cases, mid-operation reset and a 360-point sweep against atan2/hypot.
module tb_cordic_vectoring;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] x_i;
    logic [15:0] y_i;
    logic        ready;
    logic        done;
    logic [15:0] mag_o;
    logic [15:0] angle_o;

    int n_checks = 0;
    int n_pass   = 0;

    localparam real PI_R = 3.14159265358979;

    always #5 clk = ~clk;

    cordic_vectoring #(.ITERATIONS(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .x_i     (x_i),
        .y_i     (y_i),
        .ready   (ready),
        .done    (done),
        .mag_o   (mag_o),
        .angle_o (angle_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_tol(input string tag, input int obs, input int exp, input int tol);
        int d;
        d = obs - exp;
        if (d < 0) d = -d;
        n_checks++;
        assert ((d <= tol) === 1'b1) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
    endtask

    task automatic check_ang(input string tag, input int obs, input real ref_rad);
        int exp;
        int d;
        exp = int'(ref_rad * 8192.0);
        d = obs - exp;
        if (d > 25736)  d = d - 51472;
        if (d < -25736) d = d + 51472;
        if (d < 0) d = -d;
        n_checks++;
        assert ((d <= 80) === 1'b1) n_pass++;
        else $error("FAIL %s: angle observed %0d expected %0d +/- 80", tag, obs, exp);
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic do_op(input int x, input int y, output int mag, output int ang);
        int lat;
        check("ready_before_start", int'(ready), 1);
        x_i   = 16'(x);
        y_i   = 16'(y);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat);
        check("latency", lat, 9);
        mag = int'(mag_o);
        ang = int'($signed(angle_o));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  m;
        int  a;
        int  lat;
        int  n_done;
        int  xs;
        int  ys;
        real ang_r;
        real ref_m;

        reset = 1'b1;
        start = 1'b0;
        x_i   = 16'h0000;
        y_i   = 16'h0000;
        repeat (3) tick();
        check("reset_ready", int'(ready), 1);
        check("reset_done", int'(done), 0);
        check("reset_mag", int'(mag_o), 0);
        check("reset_angle", int'(angle_o), 0);
        reset = 1'b0;
        tick();

        // (256,0): traced by hand -> x=422, z=57, mag=(422*0x4DBA)>>15=256
        do_op(256, 0, m, a);
        check("c1_mag", m, 256);
        check("c1_angle", a, 57);

        // (0,256): traced by hand -> x=424, z=12811
        do_op(0, 256, m, a);
        check("c2_mag", m, 257);
        check("c2_angle", a, 12811);
        check_tol("c2_angle_tol", a, 12868, 80);

        do_op(0, -256, m, a);
        check_tol("c2n_mag", m, 256, 4);
        check_tol("c2n_angle", a, -12868, 80);

        // (-256,0) pre-rotates to (0,256) with z=+pi/2
        do_op(-256, 0, m, a);
        check("c3_mag", m, 257);
        check("c3_angle", a, 25679);
        check_tol("c3_angle_tol", a, 25736, 80);
        check("c3_clamped", int'(a <= 25736), 1);

        do_op(-32768, -32768, m, a);
        check_tol("c4_mag_neg", m, 46341, 465);
        check_tol("c4_angle_neg", a, -19302, 80);

        do_op(32767, 32767, m, a);
        check_tol("c4_mag_pos", m, 46339, 465);
        check_tol("c4_angle_pos", a, 6434, 80);

        // Zero vector held with start high; inputs change while busy
        check("c5_ready_idle", int'(ready), 1);
        x_i   = 16'h0000;
        y_i   = 16'h0000;
        start = 1'b1;
        tick();
        check("c5_ready_busy", int'(ready), 0);
        x_i = 16'(1000);
        y_i = 16'(1000);
        wait_done(lat);
        check("c5_latency", lat, 9);
        check("c5_mag", int'(mag_o), 0);
        check("c5_angle", int'(angle_o), 0);
        check("c5_ready_done_cycle", int'(ready), 1);
        tick();
        start = 1'b0;
        check("c5_b2b_accepted", int'(ready), 0);
        check("c5_done_one_cycle", int'(done), 0);
        wait_done(lat);
        check("c5_b2b_latency", lat, 9);
        check_tol("c5_b2b_mag", int'(mag_o), 1414, 16);
        check_tol("c5_b2b_angle", int'($signed(angle_o)), 6434, 80);
        tick();
        check("c5_done_cleared", int'(done), 0);

        // Nonzero outputs first so the reset clear is visible
        do_op(3000, 4000, m, a);
        check_tol("c6_pre_mag", m, 5000, 52);
        x_i   = 16'(-5000);
        y_i   = 16'(2000);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        check("c6_rst_ready", int'(ready), 1);
        check("c6_rst_done", int'(done), 0);
        check("c6_rst_mag", int'(mag_o), 0);
        check("c6_rst_angle", int'(angle_o), 0);
        reset  = 1'b0;
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        check("c6_no_stray_done", n_done, 0);

        for (int k = 0; k < 360; k++) begin
            ang_r = real'(k) * PI_R / 180.0;
            xs    = int'(10000.0 * $cos(ang_r));
            ys    = int'(10000.0 * $sin(ang_r));
            do_op(xs, ys, m, a);
            ref_m = $sqrt(real'(xs) * real'(xs) + real'(ys) * real'(ys));
            check_tol("sweep_mag", m, int'(ref_m), int'(ref_m / 100.0) + 2);
            check_ang("sweep_angle", a, $atan2(real'(ys), real'(xs)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
